// File: rtl/serial_addsub_pkg.sv
// rtl/serial_addsub_pkg.sv - shared types, mode constants and sizing helper for serial_addsub
package serial_addsub_pkg;

   typedef enum logic {
      IDLE = 1'b0,
      RUN  = 1'b1
   } state_t;

   localparam logic MODE_ADD = 1'b0;
   localparam logic MODE_SUB = 1'b1;

   // Counter width for n digits; never below one bit so NDIG=1 still has a counter.
   function automatic int clog2_min1(input int n);
      int r;
      r = 0;
      while ((1 << r) < n) begin
         r = r + 1;
      end
      return (r < 1) ? 1 : r;
   endfunction

endpackage

// File: rtl/serial_addsub_digit_adder.sv
// rtl/serial_addsub_digit_adder.sv - DIGIT-bit combinational ripple chain of full-adder cells
module serial_addsub_digit_adder #(
   parameter int DIGIT = 4
) (
   input  logic [DIGIT-1:0] a,
   input  logic [DIGIT-1:0] b,
   input  logic             ci,
   output logic [DIGIT-1:0] s,
   output logic             co,
   output logic             c_msb
);

   logic [DIGIT:0] c;

   assign c[0] = ci;

   for (genvar i = 0; i < DIGIT; i++) begin : g_fa
      assign s[i]   = a[i] ^ b[i] ^ c[i];
      assign c[i+1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
   end

   assign co    = c[DIGIT];
   // Carry into the top bit of this digit; only meaningful on the last digit for V.
   assign c_msb = c[DIGIT-1];

endmodule

// File: rtl/serial_addsub.sv
// rtl/serial_addsub.sv - digit-serial adder/subtractor with start/ready/done handshake
module serial_addsub
   import serial_addsub_pkg::*;
#(
   parameter int WIDTH = 16,
   parameter int DIGIT = 4
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic             Sub,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   input  logic             Cin,
   output logic             ready,
   output logic             done,
   output logic [WIDTH-1:0] Sum,
   output logic             Cout,
   output logic             V
);

   localparam int NDIG = WIDTH / DIGIT;
   localparam int CW   = clog2_min1(NDIG);

   state_t           state;
   state_t           state_nxt;
   logic [CW-1:0]    cnt;
   logic [WIDTH-1:0] a_q;
   logic [WIDTH-1:0] b_q;
   logic [WIDTH-1:0] sum_q;
   logic             carry_q;
   logic             cout_q;
   logic             v_q;
   logic             done_q;
   logic             accept;
   logic             last;
   logic             run;

   logic [DIGIT-1:0] a_dig;
   logic [DIGIT-1:0] b_dig;
   logic [DIGIT-1:0] s_dig;
   logic             c_out;
   logic             c_msb;

   assign last = (cnt == CW'(NDIG - 1));
   assign run  = (state == RUN);

   always_comb begin
      a_dig = '0;
      b_dig = '0;
      for (int d = 0; d < NDIG; d++) begin
         if (cnt == CW'(d)) begin
            a_dig = a_q[d*DIGIT +: DIGIT];
            b_dig = b_q[d*DIGIT +: DIGIT];
         end
      end
   end

   serial_addsub_digit_adder #(
      .DIGIT (DIGIT)
   ) u_digit_adder (
      .a     (a_dig),
      .b     (b_dig),
      .ci    (carry_q),
      .s     (s_dig),
      .co    (c_out),
      .c_msb (c_msb)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      ready     = 1'b0;
      accept    = 1'b0;
      case (state)
         IDLE: begin
            ready = 1'b1;
            if (start) begin
               accept    = 1'b1;
               state_nxt = RUN;
            end
         end
         RUN: begin
            if (last) begin
               state_nxt = IDLE;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   // Subtraction is A + ~B + ~Cin, so B and the initial carry are inverted at capture.
   always_ff @(posedge clk) begin
      if (reset) begin
         cnt     <= '0;
         a_q     <= '0;
         b_q     <= '0;
         sum_q   <= '0;
         carry_q <= 1'b0;
         cout_q  <= 1'b0;
         v_q     <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         done_q <= 1'b0;
         if (accept) begin
            a_q     <= A;
            b_q     <= (Sub == MODE_SUB) ? ~B : B;
            carry_q <= (Sub == MODE_SUB) ? ~Cin : Cin;
            cnt     <= '0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
            v_q     <= 1'b0;
         end else if (run) begin
            carry_q <= c_out;
            cnt     <= cnt + CW'(1);
            for (int d = 0; d < NDIG; d++) begin
               if (cnt == CW'(d)) begin
                  sum_q[d*DIGIT +: DIGIT] <= s_dig;
               end
            end
            if (last) begin
               cout_q <= c_out;
               v_q    <= c_msb ^ c_out;
               done_q <= 1'b1;
            end
         end
      end
   end

   assign done = done_q;
   assign Sum  = sum_q;
   assign Cout = cout_q;
   assign V    = v_q;

endmodule

// File: doc/serial_addsub.md
Name: serial_addsub

Overview:
- Parametrised, multi-cycle adder/subtractor; the next generation of the team's ripple-carry adders.
- Processes WIDTH-bit operands DIGIT bits per clock through one DIGIT-bit full-adder chain, LSB digit first. The carry is registered between digits.
- Trades latency for area in datapaths where a full-width ripple chain misses timing or costs too much.
- Start/ready/done handshake; ADD/SUB mode; carry and signed-overflow flags.

Parameters:
- WIDTH, 16, operand/result width in bits; must be a multiple of DIGIT.
- DIGIT, 4, bits processed per cycle; 1 <= DIGIT <= WIDTH.
- NDIG (derived, localparam), WIDTH/DIGIT, digits per operation.

Ports:
- clk  input  1  single clock, rising edge.
- reset  input  1  synchronous, active-high reset.
- start  input  1  request; accepted only when ready=1.
- Sub  input  1  mode: 0 = ADD, 1 = SUB; sampled with start.
- A  input  WIDTH  operand A; sampled with start.
- B  input  WIDTH  operand B; sampled with start.
- Cin  input  1  ADD: carry-in; SUB: borrow-in; sampled with start.
- ready  output  1  block idle and able to accept start.
- done  output  1  one-cycle pulse; result valid.
- Sum  output  WIDTH  result; held until the next accepted start.
- Cout  output  1  carry out of MSB (SUB: 1 = no borrow).
- V  output  1  signed two's-complement overflow.

Behaviour:
- Interface clocking: one clock domain, clk; reset is synchronous and active-high.
- Reset (sampled high at a clk edge):
  - state=IDLE; counter, operand and carry registers cleared.
  - Outputs: ready=1, done=0, Sum=0, Cout=0, V=0.
  - Reset overrides start, and aborts any operation in progress with no done pulse.
- Arithmetic:
  - ADD: Sum = A + B + Cin.
  - SUB: Sum = A + ~B + ~Cin, i.e. A - B - Cin.
  - Initial carry register = Sub ? ~Cin : Cin; B is inverted at capture when Sub=1.
  - Cout = final carry out of bit WIDTH-1.
  - V = carry into bit WIDTH-1 XOR carry out of bit WIDTH-1.
  - All results are modulo 2^WIDTH.
- FSM, two states:
  - IDLE: ready=1. start=1 at an edge latches A, B (inverted if SUB) and the initial carry; counter=0; next state RUN.
  - RUN: ready=0. Each edge adds digit[counter] of A and B with the carry register, writes the digit into Sum[counter*DIGIT +: DIGIT], updates the carry register, and increments counter.
  - RUN, last digit (counter=NDIG-1): the same edge also sets Cout and V, sets done=1 and returns to IDLE.
  - Sum bits are updated digit by digit during RUN; they are guaranteed valid only when done=1 or in IDLE afterwards.
- Latency: start accepted at edge E0; done=1 during the cycle after edge E_NDIG, i.e. NDIG cycles after acceptance.
- Throughput: one operation per NDIG cycles. start may be high in the done cycle (ready=1); it is accepted back-to-back with no bubble.
- start while ready=0 is ignored, not queued; operands in flight are unaffected.
- Degenerate case DIGIT=WIDTH (NDIG=1): single RUN cycle; done one cycle after start; counter is 1 bit wide, minimum.
- done is exactly one cycle wide. Cout and V are held with Sum until the next accepted start, then cleared on that edge.

Decomposition:
- Shared package/include: FSM state encodings (IDLE, RUN), mode constants (MODE_ADD=0, MODE_SUB=1), and the helper used to size the counter, clog2 with minimum 1.
- One natural sub-module: digit_adder, a parametrised DIGIT-bit combinational ripple chain of the team's existing FA cell.
  - Outputs: sum, carry-out, and carry into its MSB (for V).
  - Instantiated once.
- The top level holds only the FSM, counter, operand/carry registers and result assembly.

Test Plan:
- Basic ADD, WIDTH=16, DIGIT=4: A=0x1234, B=0x4321, Cin=0, Sub=0 -> Sum=0x5555, Cout=0, V=0; done exactly 4 cycles after acceptance; ready low for those 4 cycles.
- Carry ripple across digits: A=0xFFFF, B=0x0001, Cin=0, ADD -> Sum=0x0000, Cout=1, V=0. Then A=0x7FFF, B=0x0001 -> Sum=0x8000, Cout=0, V=1.
- SUB with overflow and borrow:
  - A=0x8000, B=0x0001, Cin=0, Sub=1 -> Sum=0x7FFF, Cout=1, V=1.
  - A=0x0003, B=0x0005, Cin=1, Sub=1 -> Sum=0xFFFD, Cout=0, V=0.
- Handshake:
  - start pulsed mid-RUN with different operands -> ignored; result matches the first operands.
  - start held in the done cycle -> second operation accepted; second done arrives 4 cycles later.
- Reset mid-RUN (after 2 digits) -> next cycle ready=1, done=0, Sum=0, Cout=0, V=0; no done pulse follows.
- Parameter sweep: DIGIT=1, 4 and 16, random A/B/Cin/Sub against a reference model -> all results match; done latency is 16, 4 and 1 cycles respectively.
